// File: rtl/compare_arbiter_pkg.sv
// Shared definitions for the compare arbiter: FSM states and compare-op encoding.
package compare_arbiter_pkg;

    // Arbiter control states
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

    // Bit positions inside the 3-bit compare op
    localparam int unsigned OpNegBit = 2;
    localparam int unsigned OpUnsBit = 1;
    localparam int unsigned OpLtBit  = 0;

    // Op codes (negate bit clear); OR in 3'b100 to invert the result
    localparam logic [2:0] OpSignedEq  = 3'b000;
    localparam logic [2:0] OpSignedLt  = 3'b001;
    localparam logic [2:0] OpUnsignEq  = 3'b010;
    localparam logic [2:0] OpUnsignLt  = 3'b011;
    localparam logic [2:0] OpNegate    = 3'b100;

endpackage

// File: rtl/compare_arbiter_comparator.sv
// Single-bit compare unit: equal / less-than, signed or unsigned, optional inversion.
module compare_arbiter_comparator
    import compare_arbiter_pkg::*;
#(
    parameter int unsigned data_size = 16
) (
    input  logic [2:0]           i_instr,
    input  logic [data_size-1:0] i_lhs,
    input  logic [data_size-1:0] i_rhs,
    output logic                 o_result
);

    logic w_eq;
    logic w_lt;
    logic w_raw;

    // Evaluate the selected relation and apply the negate bit
    always_comb begin
        w_eq = (i_lhs == i_rhs);
        if (i_instr[OpUnsBit]) begin
            w_lt = (i_lhs < i_rhs);
        end else begin
            w_lt = ($signed(i_lhs) < $signed(i_rhs));
        end
        w_raw    = i_instr[OpLtBit] ? w_lt : w_eq;
        o_result = w_raw ^ i_instr[OpNegBit];
    end

endmodule

// File: rtl/compare_arbiter.sv
// Round-robin arbiter that accepts one compare request at a time, evaluates it
// in a dedicated cycle and holds the result until the consumer takes it.
module compare_arbiter
    import compare_arbiter_pkg::*;
#(
    parameter int unsigned data_size = 16,
    parameter int unsigned n_req     = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [n_req-1:0]              req_valid,
    output logic [n_req-1:0]              req_ready,
    input  logic [n_req*3-1:0]            req_instr,
    input  logic [n_req*data_size-1:0]    req_lhs,
    input  logic [n_req*data_size-1:0]    req_rhs,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [$clog2(n_req)-1:0]      resp_id,
    output logic [data_size-1:0]          resp_result
);

    localparam int unsigned IdW = $clog2(n_req);

    // First valid requester at or after ptr, wrapping; MSB of the return is "found"
    function automatic logic [IdW:0] rr_pick(input logic [n_req-1:0] valid,
                                             input logic [IdW-1:0]   ptr);
        logic           found;
        logic [IdW-1:0] pick;
        logic [IdW-1:0] cand;
        int unsigned    idx;
        found = 1'b0;
        pick  = '0;
        for (int unsigned i = 0; i < n_req; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= n_req) begin
                idx = idx - n_req;
            end
            cand = IdW'(idx);
            if (!found && valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        return {found, pick};
    endfunction

    state_e               r_state;
    state_e               w_state_next;
    logic [IdW-1:0]       r_rr_ptr;
    logic [IdW-1:0]       r_grant_id;
    logic [2:0]           r_instr;
    logic [data_size-1:0] r_lhs;
    logic [data_size-1:0] r_rhs;
    logic                 r_result;

    logic [IdW:0]         w_pick;
    logic                 w_any;
    logic [IdW-1:0]       w_gid;
    logic                 w_grant;
    logic                 w_cmp_result;
    logic [IdW-1:0]       w_ptr_next;

    // Arbitration decode and pointer advance
    always_comb begin
        w_pick  = rr_pick(req_valid, r_rr_ptr);
        w_any   = w_pick[IdW];
        w_gid   = w_pick[IdW-1:0];
        w_grant = (r_state == StIdle) && w_any;
        if (r_grant_id == IdW'(n_req - 1)) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = r_grant_id + 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_any) w_state_next = StExec;
            StExec:  w_state_next = StResp;
            StResp:  if (resp_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Outputs; req_ready is forced low while reset is held
    always_comb begin
        req_ready = '0;
        if (w_grant && rst_n) begin
            req_ready[w_gid] = 1'b1;
        end
        resp_valid  = (r_state == StResp);
        resp_id     = r_grant_id;
        resp_result = {{(data_size - 1){1'b0}}, r_result};
    end

    // Datapath: latch the granted request, capture the result, advance the pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_instr    <= '0;
            r_lhs      <= '0;
            r_rhs      <= '0;
            r_result   <= 1'b0;
        end else begin
            if (w_grant) begin
                r_grant_id <= w_gid;
                r_instr    <= req_instr[w_gid*3 +: 3];
                r_lhs      <= req_lhs[w_gid*data_size +: data_size];
                r_rhs      <= req_rhs[w_gid*data_size +: data_size];
            end
            if (r_state == StExec) begin
                r_result <= w_cmp_result;
            end
            if ((r_state == StResp) && resp_ready) begin
                r_rr_ptr <= w_ptr_next;
            end
        end
    end

    compare_arbiter_comparator #(
        .data_size (data_size)
    ) u_cmp (
        .i_instr  (r_instr),
        .i_lhs    (r_lhs),
        .i_rhs    (r_rhs),
        .o_result (w_cmp_result)
    );

endmodule

// File: tb/tb_compare_arbiter.sv
// Directed bench for compare_arbiter: table of single transactions plus
// hand-written round-robin, backpressure and reset sequences.
module tb_compare_arbiter;

    localparam int unsigned DW = 16;
    localparam int unsigned NR = 4;

    logic            clk;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*3-1:0] req_instr;
    logic [NR*DW-1:0] req_lhs;
    logic [NR*DW-1:0] req_rhs;
    logic            resp_valid;
    logic            resp_ready;
    logic [1:0]      resp_id;
    logic [DW-1:0]   resp_result;

    int n_vec;
    int n_err;

    typedef struct {
        string      name;
        logic [3:0] mask;
        int         id;
        logic [2:0] op;
        logic [15:0] lhs;
        logic [15:0] rhs;
        logic       res;
    } vec_t;

    vec_t vecs[11];

    compare_arbiter #(
        .data_size (DW),
        .n_req     (NR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_instr   (req_instr),
        .req_lhs     (req_lhs),
        .req_rhs     (req_rhs),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Load operands into one slot; other slots get distinct filler values
    task automatic load_slot(input int id, input logic [2:0] op, input logic [15:0] lhs,
                             input logic [15:0] rhs);
        for (int i = 0; i < NR; i++) begin
            if (i == id) begin
                req_instr[i*3 +: 3]  = op;
                req_lhs[i*DW +: DW]  = lhs;
                req_rhs[i*DW +: DW]  = rhs;
            end else begin
                req_instr[i*3 +: 3]  = 3'b000;
                req_lhs[i*DW +: DW]  = 16'hA500 + 16'(i);
                req_rhs[i*DW +: DW]  = 16'h5A00 + 16'(i);
            end
        end
    endtask

    // One complete transaction with resp_ready held high; DUT must be idle on entry
    task automatic do_txn(input string name, input logic [3:0] mask, input int id,
                          input logic [2:0] op, input logic [15:0] lhs,
                          input logic [15:0] rhs, input logic res);
        load_slot(id, op, lhs, rhs);
        req_valid  = mask;
        resp_ready = 1'b1;
        @(negedge clk);
        check({name, " grant"}, 32'(req_ready), 32'(4'b0001 << id));
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        check({name, " exec"}, {30'd0, req_ready != 0, resp_valid}, 32'd0);
        next_cycle();
        @(negedge clk);
        check({name, " resp"}, {13'd0, resp_valid, resp_id, resp_result},
              {13'd0, 1'b1, 2'(id), 15'd0, res});
        next_cycle();
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        req_valid  = 4'hF;
        resp_ready = 1'b1;
        load_slot(0, 3'b000, 16'h0, 16'h0);

        vecs[0]  = '{"v0 slt neg",     4'b0100, 2, 3'b001, 16'hFFFF, 16'h0001, 1'b1};
        vecs[1]  = '{"v1 nult",        4'b0010, 1, 3'b111, 16'hFFFF, 16'h0001, 1'b1};
        vecs[2]  = '{"v2 neq same",    4'b0001, 0, 3'b110, 16'h1234, 16'h1234, 1'b0};
        vecs[3]  = '{"v3 seq",         4'b1001, 3, 3'b000, 16'h8000, 16'h8000, 1'b1};
        vecs[4]  = '{"v4 ult",         4'b1001, 0, 3'b011, 16'h0001, 16'hFFFF, 1'b1};
        vecs[5]  = '{"v5 slt edge",    4'b0101, 2, 3'b001, 16'h7FFF, 16'h8000, 1'b0};
        vecs[6]  = '{"v6 nslt wrap",   4'b0011, 0, 3'b101, 16'h7FFF, 16'h8000, 1'b1};
        vecs[7]  = '{"v7 ueq all",     4'b1111, 1, 3'b010, 16'h0005, 16'h0006, 1'b0};
        vecs[8]  = '{"v8 nseq",        4'b0001, 0, 3'b100, 16'h0005, 16'h0006, 1'b1};
        vecs[9]  = '{"v9 ult zero",    4'b1100, 2, 3'b011, 16'h0000, 16'h0000, 1'b0};
        vecs[10] = '{"v10 wrap to 1",  4'b0010, 1, 3'b001, 16'h0000, 16'hFFFF, 1'b0};

        // Reset values with every requester asking
        #12;
        check("rst req_ready", 32'(req_ready), 32'd0);
        check("rst resp", {13'd0, resp_valid, resp_id, resp_result}, 32'd0);
        next_cycle();
        check("rst hold req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;

        // Round robin with all requesters valid: accepts every third cycle, 0,1,2,3,0
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (c % 3 == 0) begin
                check($sformatf("rr cycle %0d", c), 32'(req_ready),
                      32'(4'b0001 << ((c / 3) % 4)));
            end else begin
                check($sformatf("rr cycle %0d", c), 32'(req_ready), 32'd0);
            end
            next_cycle();
        end
        req_valid = '0;

        for (int v = 0; v < 11; v++) begin
            do_txn(vecs[v].name, vecs[v].mask, vecs[v].id, vecs[v].op, vecs[v].lhs,
                   vecs[v].rhs, vecs[v].res);
        end

        // Backpressure: requester 1 held in RESP for five cycles while 3 waits
        load_slot(1, 3'b001, 16'h0002, 16'h0003);
        req_valid  = 4'b0010;
        resp_ready = 1'b0;
        @(negedge clk);
        check("bp grant", 32'(req_ready), 32'b0010);
        next_cycle();
        req_valid = 4'b1000;
        req_instr[9 +: 3] = 3'b000;
        req_lhs[3*DW +: DW] = 16'h0000;
        req_rhs[3*DW +: DW] = 16'h0000;
        @(negedge clk);
        check("bp exec", {30'd0, req_ready != 0, resp_valid}, 32'd0);
        next_cycle();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp hold %0d", k),
                  {9'd0, req_ready, resp_valid, resp_id, resp_result},
                  {9'd0, 4'b0000, 1'b1, 2'd1, 16'h0001});
            next_cycle();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp release", {13'd0, resp_valid, resp_id, resp_result},
              {13'd0, 1'b1, 2'd1, 16'h0001});
        next_cycle();
        @(negedge clk);
        check("bp pending grant", 32'(req_ready), 32'b1000);
        next_cycle();
        req_valid = '0;
        next_cycle();
        @(negedge clk);
        check("bp pending resp", {13'd0, resp_valid, resp_id, resp_result},
              {13'd0, 1'b1, 2'd3, 16'h0001});
        next_cycle();

        // Move the pointer to 2, then reset while requester 2 sits in RESP
        do_txn("pre-reset", 4'b0010, 1, 3'b000, 16'h0007, 16'h0007, 1'b1);
        load_slot(2, 3'b000, 16'h0001, 16'h0001);
        req_valid  = 4'b0100;
        resp_ready = 1'b0;
        @(negedge clk);
        check("mr grant", 32'(req_ready), 32'b0100);
        next_cycle();
        req_valid = '0;
        next_cycle();
        @(negedge clk);
        check("mr resp", {13'd0, resp_valid, resp_id, resp_result},
              {13'd0, 1'b1, 2'd2, 16'h0001});
        #2;
        rst_n = 1'b0;
        #1;
        check("mr async clear", {13'd0, resp_valid, resp_id, resp_result}, 32'd0);
        next_cycle();
        resp_ready = 1'b1;
        rst_n      = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("mr no resp %0d", k), {31'd0, resp_valid}, 32'd0);
            next_cycle();
        end
        req_valid = 4'hF;
        @(negedge clk);
        check("mr ptr cleared", 32'(req_ready), 32'b0001);
        next_cycle();
        req_valid = '0;
        next_cycle();
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
